// File: rtl/ctrl_sequencer.sv
// rtl/ctrl_sequencer.sv - instruction sequencer with register-file strobe, memory handshake and halt
module ctrl_sequencer #(
  parameter int                  OP_W     = 4,
  parameter logic [2**OP_W-1:0]  WR_MASK  = 16'h0400,
  parameter logic [2**OP_W-1:0]  MEM_MASK = 16'h3000,
  parameter logic [OP_W-1:0]     HLT_OP   = 4'h3,
  parameter int                  TIMEOUT  = 16,
  parameter int                  CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [OP_W-1:0]  i_opcode,
  input  logic             i_instrVld,
  output logic             o_instrRdy,
  output logic             o_memReq,
  input  logic             i_memAck,
  input  logic             i_resume,
  output logic             o_wrReg,
  output logic             o_pcInc,
  output logic             o_isHLT,
  output logic             o_memErr,
  output logic [CNT_W-1:0] o_retired
);

  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, EXEC, MEM, HALT} state_t;

  state_t            state, state_n;
  logic [OP_W-1:0]   op, op_n;
  logic [WAIT_W-1:0] wait_cnt, wait_n;
  logic [CNT_W-1:0]  retired_n;
  logic              rdy_n, req_n, wr_n, pc_n, hlt_n, err_n;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state      <= IDLE;
      op         <= '0;
      wait_cnt   <= '0;
      o_retired  <= '0;
      o_instrRdy <= 1'b0;
      o_memReq   <= 1'b0;
      o_wrReg    <= 1'b0;
      o_pcInc    <= 1'b0;
      o_isHLT    <= 1'b0;
      o_memErr   <= 1'b0;
    end else begin
      state      <= state_n;
      op         <= op_n;
      wait_cnt   <= wait_n;
      o_retired  <= retired_n;
      o_instrRdy <= rdy_n;
      o_memReq   <= req_n;
      o_wrReg    <= wr_n;
      o_pcInc    <= pc_n;
      o_isHLT    <= hlt_n;
      o_memErr   <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    op_n      = op;
    wait_n    = wait_cnt;
    retired_n = o_retired;
    req_n     = 1'b0;
    wr_n      = 1'b0;
    pc_n      = 1'b0;
    err_n     = 1'b0;
    case (state)
      IDLE: begin
        // Acceptance follows the registered ready, so the retire cycle never accepts.
        if (o_instrRdy && i_instrVld) begin
          op_n    = i_opcode;
          state_n = EXEC;
        end
      end
      EXEC: begin
        if (op == HLT_OP) begin
          state_n = HALT;
        end else if (MEM_MASK[op]) begin
          state_n = MEM;
          req_n   = 1'b1;
          wait_n  = '0;
        end else begin
          wr_n      = WR_MASK[op];
          pc_n      = 1'b1;
          retired_n = o_retired + 1'b1;
          state_n   = IDLE;
        end
      end
      MEM: begin
        if (i_memAck) begin
          wr_n      = WR_MASK[op];
          pc_n      = 1'b1;
          retired_n = o_retired + 1'b1;
          state_n   = IDLE;
        end else if ((TIMEOUT != 0) && (wait_cnt == WAIT_LAST)) begin
          err_n   = 1'b1;
          state_n = HALT;
        end else begin
          req_n  = 1'b1;
          wait_n = wait_cnt + 1'b1;
        end
      end
      HALT: begin
        if (i_resume) state_n = IDLE;
        else          err_n   = o_memErr;
      end
      default: state_n = IDLE;
    endcase
    rdy_n = (state_n == IDLE) && !pc_n;
    hlt_n = (state_n == HALT);
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb/tb_ctrl_sequencer.sv - directed table-driven bench for ctrl_sequencer
module tb_ctrl_sequencer;

  logic        clk = 1'b0;
  logic        rstn, vld, ack, resume;
  logic [3:0]  opcode;
  logic        rdy, req, wr, pc, hlt, err;
  logic [15:0] retired;
  logic        rdy2, req2, wr2, pc2, hlt2, err2;
  logic [3:0]  retired2;

  int tests = 0;
  int fails = 0;
  int exp_ret = 0;

  always #5 clk = ~clk;

  ctrl_sequencer dut (
    .i_clk(clk), .i_rstn(rstn), .i_opcode(opcode), .i_instrVld(vld),
    .o_instrRdy(rdy), .o_memReq(req), .i_memAck(ack), .i_resume(resume),
    .o_wrReg(wr), .o_pcInc(pc), .o_isHLT(hlt), .o_memErr(err), .o_retired(retired)
  );

  // Narrow counter to see the wrap, and HLT_OP also marked as memory to see HLT priority.
  ctrl_sequencer #(.CNT_W(4), .MEM_MASK(16'h3008)) dut2 (
    .i_clk(clk), .i_rstn(rstn), .i_opcode(opcode), .i_instrVld(vld),
    .o_instrRdy(rdy2), .o_memReq(req2), .i_memAck(ack), .i_resume(resume),
    .o_wrReg(wr2), .o_pcInc(pc2), .o_isHLT(hlt2), .o_memErr(err2), .o_retired(retired2)
  );

  typedef struct {
    logic [3:0] op;
    logic       exp_wr;
    logic       is_mem;
    int         ack_after;
    logic       exp_err;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0b, expected %0b", name, got, exp);
    end
  endtask

  task automatic chkn(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (!rdy && n < 10) begin
      tick();
      n++;
    end
    chk1("rdy_wait", rdy, 1'b1);
  endtask

  task automatic accept(input logic [3:0] op);
    wait_rdy();
    opcode = op;
    vld    = 1'b1;
    tick();
    vld    = 1'b0;
  endtask

  task automatic run_simple(input logic [3:0] op, input logic exp_wr);
    accept(op);
    chk1("exec_rdy", rdy, 1'b0);
    chk1("exec_pc", pc, 1'b0);
    tick();
    exp_ret++;
    chk1("ret_pc", pc, 1'b1);
    chk1("ret_wr", wr, exp_wr);
    chk1("ret_rdy", rdy, 1'b0);
    chkn("retired", 32'(retired), exp_ret % 65536);
    tick();
    chk1("post_pc", pc, 1'b0);
    chk1("post_wr", wr, 1'b0);
    chk1("post_rdy", rdy, 1'b1);
  endtask

  task automatic run_mem(input logic [3:0] op, input logic exp_wr, input int ack_after,
                         input logic exp_err);
    int n = 0;
    accept(op);
    chk1("exec_req", req, 1'b0);
    tick();
    while (req && n < 40) begin
      n++;
      if (n == ack_after) ack = 1'b1;
      tick();
      ack = 1'b0;
    end
    if (exp_err) begin
      chkn("to_req_cycles", n, 16);
      chk1("to_hlt", hlt, 1'b1);
      chk1("to_err", err, 1'b1);
      chk1("to_pc", pc, 1'b0);
      resume = 1'b1;
      tick();
      resume = 1'b0;
      chk1("resume_hlt", hlt, 1'b0);
      chk1("resume_err", err, 1'b0);
      chk1("resume_rdy", rdy, 1'b1);
      chkn("to_retired", 32'(retired), exp_ret % 65536);
    end else begin
      exp_ret++;
      chkn("mem_req_cycles", n, ack_after);
      chk1("mem_pc", pc, 1'b1);
      chk1("mem_wr", wr, exp_wr);
      chk1("mem_err", err, 1'b0);
      chk1("mem_hlt", hlt, 1'b0);
      chkn("mem_retired", 32'(retired), exp_ret % 65536);
      tick();
      chk1("mem_post_pc", pc, 1'b0);
      chk1("mem_post_rdy", rdy, 1'b1);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk1({name, "_rdy"}, rdy, 1'b0);
    chk1({name, "_req"}, req, 1'b0);
    chk1({name, "_wr"}, wr, 1'b0);
    chk1({name, "_pc"}, pc, 1'b0);
    chk1({name, "_hlt"}, hlt, 1'b0);
    chk1({name, "_err"}, err, 1'b0);
    chkn({name, "_retired"}, 32'(retired), 0);
  endtask

  initial begin
    vec_t vecs[8];
    vecs[0] = '{4'hA, 1'b1, 1'b0, 0, 1'b0};
    vecs[1] = '{4'h0, 1'b0, 1'b0, 0, 1'b0};
    vecs[2] = '{4'h5, 1'b0, 1'b0, 0, 1'b0};
    vecs[3] = '{4'hF, 1'b0, 1'b0, 0, 1'b0};
    vecs[4] = '{4'hC, 1'b0, 1'b1, 5, 1'b0};
    vecs[5] = '{4'hD, 1'b0, 1'b1, 0, 1'b1};
    vecs[6] = '{4'hD, 1'b0, 1'b1, 16, 1'b0};
    vecs[7] = '{4'hC, 1'b0, 1'b1, 1, 1'b0};

    rstn = 1'b0; vld = 1'b0; ack = 1'b0; resume = 1'b0; opcode = 4'h0;
    tick();
    tick();
    chk_all_zero("reset");
    rstn = 1'b1;
    tick();
    chk1("rdy_after_reset", rdy, 1'b1);

    foreach (vecs[i]) begin
      if (vecs[i].is_mem) run_mem(vecs[i].op, vecs[i].exp_wr, vecs[i].ack_after, vecs[i].exp_err);
      else                run_simple(vecs[i].op, vecs[i].exp_wr);
    end

    // Halt: offers and acks ignored, no strobes, resume returns to IDLE.
    accept(4'h3);
    tick();
    chk1("hlt_level", hlt, 1'b1);
    chk1("hlt_pc", pc, 1'b0);
    chk1("hlt_rdy", rdy, 1'b0);
    chk1("hlt_prio_hlt", hlt2, 1'b1);
    chk1("hlt_prio_req", req2, 1'b0);
    opcode = 4'hA;
    for (int i = 0; i < 3; i++) begin
      vld = 1'b1;
      ack = 1'b1;
      tick();
      chk1("hlt_ign_pc", pc, 1'b0);
      chk1("hlt_ign_wr", wr, 1'b0);
      chk1("hlt_ign_hlt", hlt, 1'b1);
    end
    vld = 1'b0;
    ack = 1'b0;
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk1("hlt_resume_hlt", hlt, 1'b0);
    chk1("hlt_resume_rdy", rdy, 1'b1);
    chk1("hlt_resume_err", err, 1'b0);
    chkn("hlt_retired", 32'(retired), exp_ret % 65536);

    // Reset mid-MEM aborts without strobe; a stale ack afterwards does nothing.
    accept(4'hC);
    tick();
    tick();
    chk1("midmem_req", req, 1'b1);
    rstn = 1'b0;
    tick();
    chk_all_zero("midmem_reset");
    chkn("midmem_retired2", 32'(retired2), 0);
    exp_ret = 0;
    rstn = 1'b1;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk1("stale_ack_pc", pc, 1'b0);
    chk1("stale_ack_req", req, 1'b0);
    chk1("stale_ack_rdy", rdy, 1'b1);
    tick();
    chk1("stale_ack_pc2", pc, 1'b0);

    for (int i = 0; i < 17; i++) run_simple(4'h0, 1'b0);
    chkn("wrap_retired4", 32'(retired2), 1);
    chkn("wrap_retired16", 32'(retired), 17);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/ctrl_sequencer.md
CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

Interface
REQ-001 Parameter OP_W, default 4: opcode width in bits; all masks are 2**OP_W bits wide.
REQ-002 Parameter WR_MASK, default 16'h0400: bit n set means opcode n writes the register file (0xA).
REQ-003 Parameter MEM_MASK, default 16'h3000: bit n set means opcode n needs a memory handshake (0xC, 0xD).
REQ-004 Parameter HLT_OP, default 4'h3: opcode that halts the core.
REQ-005 Parameter TIMEOUT, default 16: maximum cycles in MEM without ack; 0 disables the timeout.
REQ-006 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-007 i_clk  in  1  sole clock; all state updates on the rising edge.
REQ-008 i_rstn  in  1  synchronous, active-low reset; sampled on the rising edge of i_clk.
REQ-009 i_opcode  in  OP_W  opcode of the offered instruction.
REQ-010 i_instrVld  in  1  instruction offer valid.
REQ-011 o_instrRdy  out  1  sequencer accepts an instruction this cycle.
REQ-012 o_memReq  out  1  memory request, held until acknowledged.
REQ-013 i_memAck  in  1  memory completion; single-cycle pulse.
REQ-014 i_resume  in  1  leave HALT.
REQ-015 o_wrReg  out  1  one-cycle register-write strobe.
REQ-016 o_pcInc  out  1  one-cycle PC-advance strobe, one per retired instruction.
REQ-017 o_isHLT  out  1  level, high while in HALT.
REQ-018 o_memErr  out  1  level, high while in HALT if the halt was caused by a timeout.
REQ-019 o_retired  out  CNT_W  count of retired instructions.

Function
REQ-020 FSM states: IDLE, EXEC, MEM, HALT; all outputs registered.
REQ-021 o_instrRdy SHALL be high only in IDLE.
REQ-022 IDLE: when i_instrVld=1, latch i_opcode into the op register and go to EXEC; otherwise stay in IDLE.
REQ-023 EXEC, op==HLT_OP: go to HALT; no o_pcInc; o_retired unchanged.
REQ-024 EXEC, MEM_MASK[op]=1: go to MEM; o_memReq rises in the same cycle MEM is entered; the wait counter clears to 0.
REQ-025 EXEC, otherwise: pulse o_wrReg=WR_MASK[op] and o_pcInc=1 for one cycle; o_retired increments; go to IDLE.
REQ-026 Latency: a non-memory instruction retires with strobes 2 cycles after acceptance; back-to-back acceptance is possible every 3 cycles.
REQ-027 MEM: o_memReq stays high; the wait counter increments each cycle without i_memAck.
REQ-028 MEM, i_memAck=1: drop o_memReq; pulse o_wrReg=WR_MASK[op] and o_pcInc; o_retired increments; go to IDLE.
REQ-029 MEM, TIMEOUT!=0, counter==TIMEOUT-1, and no ack: drop o_memReq; set o_memErr; go to HALT.
REQ-030 If ack and timeout occur in the same cycle, ack wins (normal retire, no error).
REQ-031 HALT: o_isHLT=1; i_resume=1 goes to IDLE and clears o_isHLT and o_memErr on the next edge; no strobes are generated.
REQ-032 The sequencer SHALL ignore i_resume outside HALT, i_memAck outside MEM, and i_instrVld outside IDLE.
REQ-033 o_retired SHALL wrap from 2**CNT_W-1 to 0 without any flag.
REQ-034 Opcodes set in both MEM_MASK and equal to HLT_OP SHALL be treated as HLT, which takes priority.

Reset
REQ-035 While i_rstn=0 at an edge: state goes to IDLE; op register, wait counter and o_retired clear to 0; all 1-bit outputs go to 0.
REQ-036 After reset, o_instrRdy SHALL be 1 in the first cycle after the reset is released.
REQ-037 Reset asserted in any state, including mid-MEM with o_memReq=1, SHALL abort the operation with no strobe; a later i_memAck is ignored.

Verification
REQ-038 Offer 0xA in IDLE -> o_wrReg=1 and o_pcInc=1 for exactly one cycle, 2 cycles after acceptance; o_retired 0->1.
REQ-039 Offer 0xC, ack after 5 cycles -> o_memReq high 5 cycles, then one o_pcInc with o_wrReg=0; o_retired increments.
REQ-040 Offer 0xD, never ack, TIMEOUT=16 -> o_memReq high 16 cycles; then o_isHLT=1 and o_memErr=1; i_resume -> both 0, o_instrRdy=1.
REQ-041 Offer 0x3 -> o_isHLT=1 with no strobes; i_instrVld pulses ignored; i_resume returns to IDLE; o_retired unchanged.
REQ-042 Ack in the same cycle as the timeout -> normal retire, o_memErr=0; also reset mid-MEM -> all outputs 0, and a stale ack produces no strobe.
REQ-043 With CNT_W=4, retire 17 instructions -> o_retired=1 (wrapped).
